// File: rtl/dcache_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | dcache_pkg: shared dcache types, port select enum, arbiter state.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dcache_pkg;

   typedef enum logic [1:0] {
      PORT_PTW   = 2'd0,
      PORT_LOAD  = 2'd1,
      PORT_STORE = 2'd2
   } request_port_select_t;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_REQUEST = 2'd1,
      ARB_BUSY    = 2'd2
   } dcache_arb_state_t;

   localparam int unsigned DCACHE_PTW_STARVE_LIMIT = 4;

endpackage
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | dcache_port_arbiter: PTW/LOAD/STORE arbiter toward the dcache      |
// | controller with PTW priority, starvation guard and kill handling.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dcache_port_arbiter
   import dcache_pkg::*;
#(
   parameter int unsigned PTW_STARVE_LIMIT = DCACHE_PTW_STARVE_LIMIT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] port_req_i,
   input  logic [2:0] port_kill_i,
   output logic [2:0] port_gnt_o,
   output logic [2:0] port_rvalid_o,
   output logic       ctrl_req_o,
   output logic [1:0] ctrl_sel_o,
   input  logic       ctrl_gnt_i,
   input  logic       ctrl_done_i,
   output logic       busy_o
);

   localparam int unsigned CNT_W = (PTW_STARVE_LIMIT > 0) ? $clog2(PTW_STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(PTW_STARVE_LIMIT);

   dcache_arb_state_t    state_q, state_d;
   request_port_select_t sel_q, sel_d;
   logic [CNT_W-1:0]     starve_q, starve_d;
   logic                 kill_q, kill_d;
   logic                 rr_store_q, rr_store_d;
   logic                 ls_req;

   // PTW wins unless starved and a load/store is actually waiting.
   function automatic request_port_select_t pick_winner(input logic [2:0] req,
                                                        input logic       starved,
                                                        input logic       rr_store);
      pick_winner = PORT_PTW;
      if (req[PORT_PTW] && !(starved && (req[PORT_LOAD] || req[PORT_STORE])))
         pick_winner = PORT_PTW;
      else if (req[PORT_LOAD] && req[PORT_STORE])
         pick_winner = rr_store ? PORT_STORE : PORT_LOAD;
      else if (req[PORT_STORE])
         pick_winner = PORT_STORE;
      else if (req[PORT_LOAD])
         pick_winner = PORT_LOAD;
   endfunction

   assign ls_req     = port_req_i[PORT_LOAD] | port_req_i[PORT_STORE];
   assign ctrl_sel_o = sel_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ARB_IDLE;
         sel_q      <= PORT_PTW;
         starve_q   <= '0;
         kill_q     <= 1'b0;
         rr_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         starve_q   <= starve_d;
         kill_q     <= kill_d;
         rr_store_q <= rr_store_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      starve_d   = starve_q;
      kill_d     = kill_q;
      rr_store_d = rr_store_q;
      case (state_q)
         ARB_IDLE: begin
            if (|port_req_i) begin
               sel_d   = pick_winner(port_req_i, starve_q == STARVE_MAX, rr_store_q);
               state_d = ARB_REQUEST;
            end
         end
         ARB_REQUEST: begin
            // A grant in the same cycle as a kill still completes.
            if (ctrl_gnt_i) begin
               state_d = ARB_BUSY;
               if (sel_q == PORT_PTW) begin
                  if (ls_req && (starve_q != STARVE_MAX))
                     starve_d = starve_q + CNT_W'(1);
               end else begin
                  starve_d   = '0;
                  rr_store_d = (sel_q == PORT_LOAD);
               end
            end else if (port_kill_i[sel_q]) begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (port_kill_i[sel_q])
               kill_d = 1'b1;
            if (ctrl_done_i) begin
               state_d = ARB_IDLE;
               kill_d  = 1'b0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      port_gnt_o    = '0;
      port_rvalid_o = '0;
      ctrl_req_o    = 1'b0;
      busy_o        = 1'b0;
      if (!rst_i) begin
         ctrl_req_o = (state_q == ARB_REQUEST);
         busy_o     = (state_q != ARB_IDLE);
         if ((state_q == ARB_REQUEST) && ctrl_gnt_i)
            port_gnt_o[sel_q] = 1'b1;
         if ((state_q == ARB_BUSY) && ctrl_done_i && !kill_q && !port_kill_i[sel_q])
            port_rvalid_o[sel_q] = 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      ((state_q == ARB_REQUEST) && !port_kill_i[sel_q]) |-> port_req_i[sel_q])
      else $error("requester dropped port_req_i before grant");

   a_onehot: assert property (@(posedge clk_i)
      $onehot0(port_gnt_o) && $onehot0(port_rvalid_o))
      else $error("multiple grant or rvalid bits");
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_dcache_port_arbiter: directed self-checking bench.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dcache_port_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [2:0] port_req_i;
   logic [2:0] port_kill_i;
   logic [2:0] port_gnt_o;
   logic [2:0] port_rvalid_o;
   logic       ctrl_req_o;
   logic [1:0] ctrl_sel_o;
   logic       ctrl_gnt_i;
   logic       ctrl_done_i;
   logic       busy_o;

   int n_total = 0;
   int n_bad   = 0;

   logic [2:0] got [8];
   int         got_n;
   int         rv_n;
   int         g2_n;

   logic [2:0] exp_rr [4];
   logic [2:0] exp_st [6];

   dcache_port_arbiter #(.PTW_STARVE_LIMIT(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .port_req_i    (port_req_i),
      .port_kill_i   (port_kill_i),
      .port_gnt_o    (port_gnt_o),
      .port_rvalid_o (port_rvalid_o),
      .ctrl_req_o    (ctrl_req_o),
      .ctrl_sel_o    (ctrl_sel_o),
      .ctrl_gnt_i    (ctrl_gnt_i),
      .ctrl_done_i   (ctrl_done_i),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      port_req_i  = '0;
      port_kill_i = '0;
      ctrl_gnt_i  = 1'b0;
      ctrl_done_i = 1'b0;
      adv();
      rst_i = 1'b0;
   endtask

   // Records grant pulses; ctrl_done_i is raised dly cycles after each grant.
   task automatic collect(input int n, input int dly);
      int wait_cnt;
      wait_cnt = -1;
      got_n    = 0;
      rv_n     = 0;
      for (int i = 0; i < 8; i++) got[i] = '0;
      for (int cyc = 0; cyc < 300 && got_n < n; cyc++) begin
         ctrl_done_i = (wait_cnt == 0);
         smp();
         if (port_rvalid_o != 3'b000) rv_n++;
         if (port_gnt_o != 3'b000) begin
            got[got_n] = port_gnt_o;
            got_n++;
            wait_cnt = dly - 1;
         end else if (wait_cnt > 0) begin
            wait_cnt--;
         end else if (wait_cnt == 0) begin
            wait_cnt = -1;
         end
         adv();
      end
      ctrl_done_i = 1'b0;
   endtask

   task automatic drain();
      port_req_i  = '0;
      ctrl_gnt_i  = 1'b0;
      ctrl_done_i = 1'b1;
      adv();
      ctrl_done_i = 1'b0;
      smp();
      chk("drain_busy", busy_o, 0);
      adv();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      exp_rr = '{3'b010, 3'b100, 3'b010, 3'b100};
      exp_st = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

      // Reset with all ports requesting
      rst_i       = 1'b1;
      port_req_i  = 3'b111;
      port_kill_i = '0;
      ctrl_gnt_i  = 1'b0;
      ctrl_done_i = 1'b0;
      smp();
      chk("rst_gnt", port_gnt_o, 0);
      chk("rst_rvalid", port_rvalid_o, 0);
      chk("rst_ctrl_req", ctrl_req_o, 0);
      chk("rst_busy", busy_o, 0);
      adv();
      smp();
      chk("rst2_ctrl_req", ctrl_req_o, 0);
      chk("rst2_busy", busy_o, 0);
      adv();
      rst_i = 1'b0;
      smp();
      chk("post1_ctrl_req", ctrl_req_o, 0);
      chk("post1_busy", busy_o, 0);
      chk("post1_gnt", port_gnt_o, 0);
      adv();
      smp();
      chk("post2_ctrl_req", ctrl_req_o, 1);
      chk("post2_sel", ctrl_sel_o, 0);
      chk("post2_busy", busy_o, 1);
      adv();

      // Round-robin LOAD/STORE
      do_reset();
      port_req_i = 3'b110;
      ctrl_gnt_i = 1'b1;
      collect(4, 2);
      chk("rr_count", got_n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), got[i], exp_rr[i]);
      chk("rr_rvalid_count", rv_n, 3);
      drain();

      // Starvation guard
      do_reset();
      port_req_i = 3'b011;
      ctrl_gnt_i = 1'b1;
      collect(6, 1);
      chk("st_count", got_n, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("st_grant%0d", i), got[i], exp_st[i]);
      chk("st_rvalid_count", rv_n, 5);
      drain();

      // Kill in BUSY suppresses rvalid
      do_reset();
      port_req_i = 3'b010;
      ctrl_gnt_i = 1'b1;
      adv();
      smp();
      chk("kb_gnt", port_gnt_o, 3'b010);
      adv();
      port_req_i  = '0;
      ctrl_gnt_i  = 1'b0;
      port_kill_i = 3'b010;
      smp();
      chk("kb_busy1", busy_o, 1);
      adv();
      port_kill_i = '0;
      adv();
      adv();
      ctrl_done_i = 1'b1;
      smp();
      chk("kb_rvalid", port_rvalid_o, 0);
      chk("kb_busy4", busy_o, 1);
      adv();
      ctrl_done_i = 1'b0;
      smp();
      chk("kb_idle", busy_o, 0);
      adv();

      // Back-pressure on STORE
      do_reset();
      g2_n       = 0;
      port_req_i = 3'b100;
      adv();
      for (int i = 0; i < 5; i++) begin
         smp();
         chk($sformatf("bp_req%0d", i), ctrl_req_o, 1);
         chk($sformatf("bp_sel%0d", i), ctrl_sel_o, 2);
         if (port_gnt_o[2]) g2_n++;
         adv();
      end
      ctrl_gnt_i = 1'b1;
      smp();
      chk("bp_gnt", port_gnt_o, 3'b100);
      if (port_gnt_o[2]) g2_n++;
      adv();
      ctrl_gnt_i = 1'b0;
      port_req_i = '0;
      smp();
      chk("bp_req_drop", ctrl_req_o, 0);
      chk("bp_busy", busy_o, 1);
      if (port_gnt_o[2]) g2_n++;
      chk("bp_gnt_pulses", g2_n, 1);
      adv();
      ctrl_done_i = 1'b1;
      smp();
      chk("bp_rvalid", port_rvalid_o, 3'b100);
      adv();
      ctrl_done_i = 1'b0;
      smp();
      chk("bp_idle", busy_o, 0);
      adv();

      // Kill in REQUEST: non-selected ignored, selected aborts
      do_reset();
      port_req_i = 3'b100;
      adv();
      port_kill_i = 3'b010;
      smp();
      chk("kr_other_req", ctrl_req_o, 1);
      adv();
      port_kill_i = 3'b100;
      port_req_i  = '0;
      smp();
      chk("kr_still_req", ctrl_req_o, 1);
      chk("kr_no_gnt", port_gnt_o, 0);
      adv();
      port_kill_i = '0;
      smp();
      chk("kr_idle", busy_o, 0);
      adv();

      // Kill and grant together: grant wins, rvalid delivered
      port_req_i = 3'b001;
      adv();
      port_kill_i = 3'b001;
      ctrl_gnt_i  = 1'b1;
      smp();
      chk("kg_gnt", port_gnt_o, 3'b001);
      adv();
      port_kill_i = '0;
      ctrl_gnt_i  = 1'b0;
      port_req_i  = '0;
      smp();
      chk("kg_busy", busy_o, 1);
      adv();
      ctrl_done_i = 1'b1;
      smp();
      chk("kg_rvalid", port_rvalid_o, 3'b001);
      adv();
      ctrl_done_i = 1'b0;

      // Reset in BUSY abandons the transaction
      do_reset();
      port_req_i = 3'b001;
      ctrl_gnt_i = 1'b1;
      adv();
      adv();
      port_req_i = '0;
      ctrl_gnt_i = 1'b0;
      smp();
      chk("mr_busy", busy_o, 1);
      adv();
      rst_i = 1'b1;
      smp();
      chk("mr_rst_busy", busy_o, 0);
      adv();
      rst_i       = 1'b0;
      ctrl_done_i = 1'b1;
      smp();
      chk("mr_rvalid", port_rvalid_o, 0);
      chk("mr_idle", busy_o, 0);
      adv();
      ctrl_done_i = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 The block SHALL have parameter PTW_STARVE_LIMIT, default 4: the number of consecutive PTW grants allowed while a load or store request is pending.
REQ-002 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 port_req_i  in  3  request per port, indexed by request_port_select_t (0 PTW, 1 LOAD, 2 STORE).
REQ-005 port_kill_i  in  3  per-port kill of that port's in-flight request.
REQ-006 port_gnt_o  out  3  one-cycle grant pulse per port.
REQ-007 port_rvalid_o  out  3  one-cycle completion pulse per port.
REQ-008 ctrl_req_o  out  1  request to the dcache controller.
REQ-009 ctrl_sel_o  out  2  selected port (request_port_select_t); valid while ctrl_req_o=1 or state=BUSY.
REQ-010 ctrl_gnt_i  in  1  controller accepts the request.
REQ-011 ctrl_done_i  in  1  controller finished the accepted request.
REQ-012 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-013 The arbiter FSM SHALL have exactly three states: IDLE, REQUEST and BUSY.
REQ-014 IDLE: if any port_req_i bit is set, the FSM SHALL register the winner into ctrl_sel_o and enter REQUEST; ctrl_req_o SHALL rise the cycle after the request is seen (1-cycle latency).
REQ-015 Winner: PTW SHALL win over LOAD/STORE unless the starvation counter equals PTW_STARVE_LIMIT.
REQ-016 Between LOAD and STORE, the winner SHALL be round-robin: the port not granted last wins a tie; the round-robin pointer resets to favour LOAD.
REQ-017 Starvation counter: SHALL increment on a PTW grant while LOAD or STORE is requesting; SHALL clear on any LOAD/STORE grant; SHALL saturate at PTW_STARVE_LIMIT.
REQ-018 REQUEST: ctrl_req_o and ctrl_sel_o SHALL hold stable until ctrl_gnt_i=1.
REQ-019 In the ctrl_gnt_i cycle, port_gnt_o[ctrl_sel_o] SHALL pulse combinationally and the FSM SHALL enter BUSY; ctrl_req_o SHALL drop the next cycle.
REQ-020 BUSY: on ctrl_done_i, port_rvalid_o[ctrl_sel_o] SHALL pulse the same cycle and the FSM SHALL enter IDLE.
REQ-021 ctrl_done_i and a new port request in the same cycle SHALL cost exactly one IDLE bubble cycle; no overlapping transactions are allowed.
REQ-022 Kill in REQUEST: if port_kill_i[ctrl_sel_o]=1 and ctrl_gnt_i=0, the FSM SHALL return to IDLE without a grant.
REQ-023 Kill in REQUEST: if port_kill_i[ctrl_sel_o]=1 and ctrl_gnt_i=1 in the same cycle, the grant wins and the FSM proceeds to BUSY.
REQ-024 Kill in BUSY: a kill flag SHALL be set; the FSM SHALL still wait for ctrl_done_i; the port_rvalid_o pulse SHALL be suppressed; the flag clears on exit.
REQ-025 A kill on a non-selected port SHALL be ignored.
REQ-026 At most one bit of port_gnt_o, and at most one bit of port_rvalid_o, SHALL be high in any cycle.
REQ-027 ctrl_gnt_i outside REQUEST and ctrl_done_i outside BUSY SHALL be ignored.
REQ-028 A requester dropping port_req_i before its grant is a protocol violation, flagged by a simulation assertion; the arbiter still completes its REQUEST handshake.

Reset
REQ-029 In the cycle rst_i is sampled high, the block SHALL enter IDLE and clear ctrl_sel_o=0, the starvation counter, the kill flag and the round-robin pointer (favour LOAD).
REQ-030 While rst_i is high, and in the first cycle after reset, port_gnt_o=0, port_rvalid_o=0, ctrl_req_o=0 and busy_o=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction silently: no port_rvalid_o pulse.

Structure
REQ-032 dcache_pkg SHALL gain the arbiter state enum (dcache_arb_state_t) and the default PTW_STARVE_LIMIT constant; the block SHALL reuse request_port_select_t.
REQ-033 The block SHALL be a single module with no sub-modules; the winner selection is a local function.

Verification
REQ-034 Reset: port_req_i=3'b111 during reset -> all outputs 0; ctrl_req_o=1 with ctrl_sel_o=PTW the second cycle after release.
REQ-035 Round-robin: LOAD and STORE held continuously, ctrl_gnt_i immediate, ctrl_done_i after 2 cycles -> grant order LOAD, STORE, LOAD, STORE.
REQ-036 Starvation: PTW and LOAD held with PTW_STARVE_LIMIT=4 -> four PTW grants, then one LOAD grant, then PTW again.
REQ-037 Kill: LOAD granted, port_kill_i[1] pulsed in BUSY, ctrl_done_i 3 cycles later -> no port_rvalid_o[1]; IDLE next cycle.
REQ-038 Back-pressure: ctrl_gnt_i held low 5 cycles with STORE requesting -> ctrl_req_o and ctrl_sel_o=2 stable for all 5 cycles; port_gnt_o[2] pulses exactly once.
REQ-039 Mid-reset: rst_i asserted in BUSY -> IDLE next cycle; a later ctrl_done_i produces no port_rvalid_o pulse.
